// File: rtl/hazard_if.sv
// ID/EX hazard-unit signal bundle.
// The pipeline drives through the master modport; the interlock uses the slave modport.
interface hazard_if #(
    parameter int CNT_W = 32
) ();
    logic             valid_id;
    logic [3:0]       Y_id;
    logic [3:0]       X_id;
    logic [3:0]       Z_id;
    logic             use_y;
    logic             use_x;
    logic [2:0]       rd_id;
    logic [2:0]       wr_id;
    logic             fpu_id;
    logic             ld_ex;
    logic [2:0]       RW_ex;
    logic [3:0]       Z_ex;
    logic             flush;
    logic             stall_pc;
    logic             stall_id;
    logic             bubble_ex;
    logic             fpu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output valid_id, Y_id, X_id, Z_id, use_y, use_x, rd_id, wr_id, fpu_id,
               ld_ex, RW_ex, Z_ex, flush,
        input  stall_pc, stall_id, bubble_ex, fpu_busy, stall_cnt
    );

    modport slave (
        input  valid_id, Y_id, X_id, Z_id, use_y, use_x, rd_id, wr_id, fpu_id,
               ld_ex, RW_ex, Z_ex, flush,
        output stall_pc, stall_id, bubble_ex, fpu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Decode-stage interlock: load-use and multi-cycle FPU hazards, with a per-F-register
// countdown scoreboard and a saturating stall-cycle counter.
module hazard_unit #(
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hif
);
    localparam logic [2:0] LAT = 3'(FPU_LAT);

    logic [15:0][2:0] r_sb;
    logic [CNT_W-1:0] r_cnt;

    logic w_lu;
    logic w_fh;
    logic w_fw;
    logic w_stall;
    logic w_issue;

    assign w_lu = hif.valid_id & hif.ld_ex & hif.RW_ex[1] & hif.rd_id[1] &
                  ((hif.use_y & (hif.Y_id == hif.Z_ex)) |
                   (hif.use_x & (hif.X_id == hif.Z_ex)));

    // Only F sources consult the scoreboard; sb == 1 means the result is forwardable now.
    assign w_fh = hif.valid_id & hif.rd_id[2] &
                  ((hif.use_y & (r_sb[hif.Y_id] >= 3'd2)) |
                   (hif.use_x & (r_sb[hif.X_id] >= 3'd2)));

    assign w_fw    = hif.valid_id & hif.fpu_id & (r_sb[hif.Z_id] >= 3'd2);
    assign w_stall = (w_lu | w_fh | w_fw) & ~hif.flush;
    assign w_issue = hif.valid_id & hif.fpu_id & ~w_stall & ~hif.flush;

    assign hif.stall_pc  = w_stall;
    assign hif.stall_id  = w_stall;
    assign hif.bubble_ex = w_stall | hif.flush;
    assign hif.fpu_busy  = |r_sb;
    assign hif.stall_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb  <= '0;
            r_cnt <= '0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (w_issue && (hif.Z_id == 4'(r)))
                    r_sb[r] <= LAT;
                else if (r_sb[r] != 3'd0)
                    r_sb[r] <= r_sb[r] - 3'd1;
            end
            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a model that tracks each F register's result-ready cycle.
module tb_hazard_unit;
    localparam int LAT = 4;

    logic clk;
    logic rst_n;

    hazard_if #(.CNT_W(32)) hif ();
    hazard_if #(.CNT_W(4))  hif2 ();

    hazard_unit #(.FPU_LAT(LAT), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .hif(hif));
    hazard_unit #(.FPU_LAT(LAT), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .hif(hif2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: sb_end[r] is the cycle at which register r's countdown reaches zero.
    longint cyc = 0;
    longint sb_end [16];
    longint exp_cnt = 0;

    function automatic longint sbv(input logic [3:0] r);
        return (sb_end[r] > cyc) ? sb_end[r] - cyc : 0;
    endfunction

    function automatic bit m_stall();
        bit lu, fh, fw;
        lu = hif.valid_id && hif.ld_ex && hif.RW_ex[1] && hif.rd_id[1] &&
             ((hif.use_y && hif.Y_id == hif.Z_ex) || (hif.use_x && hif.X_id == hif.Z_ex));
        fh = hif.valid_id && hif.rd_id[2] &&
             ((hif.use_y && sbv(hif.Y_id) >= 2) || (hif.use_x && sbv(hif.X_id) >= 2));
        fw = hif.valid_id && hif.fpu_id && sbv(hif.Z_id) >= 2;
        return (lu || fh || fw) && !hif.flush;
    endfunction

    function automatic bit m_busy();
        bit b = 0;
        for (int r = 0; r < 16; r++) if (sbv(4'(r)) > 0) b = 1;
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) sb_end[r] = 0;
        exp_cnt = 0;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit s, iss;
        logic [3:0] z;
        s   = m_stall();
        iss = hif.valid_id && hif.fpu_id && !s && !hif.flush;
        z   = hif.Z_id;
        @(posedge clk);
        cyc++;
        if (iss) sb_end[z] = cyc + LAT;
        if (s && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic idle();
        hif.valid_id = 0; hif.Y_id = 0; hif.X_id = 0; hif.Z_id = 0;
        hif.use_y = 0; hif.use_x = 0; hif.rd_id = 0; hif.wr_id = 0; hif.fpu_id = 0;
        hif.ld_ex = 0; hif.RW_ex = 0; hif.Z_ex = 0; hif.flush = 0;
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 2) tick();
    endtask

    task automatic fpu_op(input logic [3:0] z);
        idle();
        hif.valid_id = 1; hif.fpu_id = 1; hif.wr_id = 3'b100; hif.Z_id = z;
    endtask

    task automatic f_consumer(input logic [3:0] y);
        idle();
        hif.valid_id = 1; hif.rd_id = 3'b100; hif.use_y = 1; hif.Y_id = y;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        hif2.valid_id = 0; hif2.Y_id = 0; hif2.X_id = 0; hif2.Z_id = 0;
        hif2.use_y = 0; hif2.use_x = 0; hif2.rd_id = 0; hif2.wr_id = 0; hif2.fpu_id = 0;
        hif2.ld_ex = 0; hif2.RW_ex = 0; hif2.Z_ex = 0; hif2.flush = 0;
        model_reset();
        @(posedge clk); @(negedge clk);
        checks++; if (hif.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", hif.stall_cnt); end
        checks++; if (hif.fpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", hif.fpu_busy); end
        checks++; if ({hif.stall_pc, hif.stall_id, hif.bubble_ex} !== 3'b000) begin
            errors++; $display("FAIL reset_stall got %b want 000", {hif.stall_pc, hif.stall_id, hif.bubble_ex}); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        hif.valid_id = 1; hif.rd_id = 3'b010; hif.use_y = 1; hif.Y_id = 5;
        hif.ld_ex = 1; hif.RW_ex = 3'b010; hif.Z_ex = 5;
        #1;
        checks++; if ({hif.stall_pc, hif.stall_id, hif.bubble_ex} !== 3'b111) begin
            errors++; $display("FAIL lu_stall got %b want 111", {hif.stall_pc, hif.stall_id, hif.bubble_ex}); end
        tick();
        hif.ld_ex = 0; hif.RW_ex = 0;
        #1;
        checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", hif.stall_pc); end
        checks++; if (hif.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", hif.stall_cnt); end
        hif.ld_ex = 1; hif.RW_ex = 3'b010; hif.Y_id = 6;
        #1;
        checks++; if ({hif.stall_pc, hif.bubble_ex} !== 2'b00) begin
            errors++; $display("FAIL lu_nomatch got %b want 00", {hif.stall_pc, hif.bubble_ex}); end
        tick();
    endtask

    task automatic test_fpu_raw();
        longint base;
        drain();
        base = exp_cnt;
        fpu_op(3);
        #1;
        checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL raw_issue got %b want 0", hif.stall_pc); end
        tick();
        f_consumer(3);
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (hif.stall_pc !== 1'b1) begin errors++; $display("FAIL raw_stall_t%0d got %b want 1", k, hif.stall_pc); end
            tick();
        end
        #1;
        checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL raw_proceed got %b want 0", hif.stall_pc); end
        checks++; if (64'(hif.stall_cnt) !== base + 3) begin errors++; $display("FAIL raw_cnt got %0d want %0d", hif.stall_cnt, base + 3); end
        checks++; if (hif.fpu_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_t4 got %b want 1", hif.fpu_busy); end
        tick();
        idle();
        #1;
        checks++; if (hif.fpu_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_t5 got %b want 0", hif.fpu_busy); end
    endtask

    task automatic test_flush();
        longint base;
        drain();
        fpu_op(3);
        tick();
        base = exp_cnt;
        // Killed instruction both reads F3 and would issue to F9.
        f_consumer(3);
        hif.fpu_id = 1; hif.wr_id = 3'b100; hif.Z_id = 9; hif.flush = 1;
        #1;
        checks++; if ({hif.stall_pc, hif.bubble_ex} !== 2'b01) begin
            errors++; $display("FAIL flush_out got %b want 01", {hif.stall_pc, hif.bubble_ex}); end
        tick();
        checks++; if (64'(hif.stall_cnt) !== base) begin errors++; $display("FAIL flush_cnt got %0d want %0d", hif.stall_cnt, base); end
        f_consumer(9);
        #1;
        checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL flush_noissue got %b want 0", hif.stall_pc); end
        tick();
    endtask

    task automatic test_waw();
        drain();
        fpu_op(7);
        tick();
        fpu_op(7);
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (hif.stall_pc !== 1'b1) begin errors++; $display("FAIL waw_stall_t%0d got %b want 1", k, hif.stall_pc); end
            tick();
        end
        #1;
        checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL waw_issue got %b want 0", hif.stall_pc); end
        tick();
        // sb[7] restarted at FPU_LAT: a reader must now stall three cycles again.
        f_consumer(7);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (hif.stall_pc !== (k <= 3)) begin errors++; $display("FAIL waw_reload_t%0d got %b want %b", k, hif.stall_pc, k <= 3); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int k = 1; k <= 5; k++) begin
            fpu_op(4'(k));
            #1;
            checks++; if (hif.stall_pc !== 1'b0) begin errors++; $display("FAIL b2b_op%0d got %b want 0", k, hif.stall_pc); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        drain();
        fpu_op(3);
        tick();
        f_consumer(3);
        tick();
        #1;
        checks++; if (hif.stall_pc !== 1'b1) begin errors++; $display("FAIL areset_pre got %b want 1", hif.stall_pc); end
        #1;
        rst_n = 0;
        #1;
        checks++; if ({hif.stall_pc, hif.stall_id} !== 2'b00) begin
            errors++; $display("FAIL areset_stall got %b want 00", {hif.stall_pc, hif.stall_id}); end
        checks++; if (hif.fpu_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", hif.fpu_busy); end
        checks++; if (hif.stall_cnt !== 32'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", hif.stall_cnt); end
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        drain();
        for (int n = 0; n < 400; n++) begin
            bit s;
            hif.valid_id = ($urandom_range(0, 7) != 0);
            hif.Y_id = 4'($urandom_range(0, 3));
            hif.X_id = 4'($urandom_range(0, 3));
            hif.Z_id = 4'($urandom_range(0, 3));
            hif.use_y = 1'($urandom);
            hif.use_x = 1'($urandom);
            hif.rd_id = 3'(1 << $urandom_range(0, 3));
            hif.fpu_id = ($urandom_range(0, 2) == 0);
            hif.wr_id = hif.fpu_id ? 3'b100 : 3'(1 << $urandom_range(0, 3));
            hif.ld_ex = 1'($urandom);
            hif.RW_ex = 3'(1 << $urandom_range(0, 3));
            hif.Z_ex = 4'($urandom_range(0, 3));
            hif.flush = ($urandom_range(0, 7) == 0);
            #1;
            s = m_stall();
            checks++;
            if ({hif.stall_pc, hif.stall_id, hif.bubble_ex, hif.fpu_busy} !== {s, s, s | hif.flush, m_busy()} ||
                64'(hif.stall_cnt) !== exp_cnt) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand_%0d got pc%b id%b bub%b busy%b cnt%0d want pc%b id%b bub%b busy%b cnt%0d",
                             n, hif.stall_pc, hif.stall_id, hif.bubble_ex, hif.fpu_busy, hif.stall_cnt,
                             s, s, s | hif.flush, m_busy(), exp_cnt);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_saturation();
        hif2.valid_id = 1; hif2.rd_id = 3'b010; hif2.use_x = 1; hif2.X_id = 2;
        hif2.ld_ex = 1; hif2.RW_ex = 3'b010; hif2.Z_ex = 2;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (hif2.stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d want 10", hif2.stall_cnt); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (hif2.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_top got %0d want 15", hif2.stall_cnt); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (hif2.stall_cnt !== 4'd15 || hif2.stall_pc !== 1'b1) begin
            errors++; $display("FAIL sat_hold got cnt%0d stall%b want cnt15 stall1", hif2.stall_cnt, hif2.stall_pc); end
    endtask

    initial begin
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_fpu_raw();
        test_flush();
        test_waw();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
